// File: rtl/sys_array_drain.sv
// sys_array_drain: result-side drain for the systolic matrix multiplier.
// On each rising edge of arr_done it snapshots all M*K result words. It then
// streams them row-major over a valid/ready port, one word per handshake.
// A done edge that arrives while a frame is held is dropped and flagged in
// the sticky overrun bit.
module sys_array_drain #(
    parameter int M     = 2,
    parameter int K     = 2,
    parameter int IDX_W = (M * K > 1) ? $clog2(M * K) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arr_done,
    input  logic                 arr_err,
    input  logic [M*K*32-1:0]    arr_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_dat,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 out_err,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 clr_ovr
);

    localparam int N = M * K;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state;
    logic             done_q;
    logic [31:0]      frame_buf [N];
    logic [IDX_W-1:0] idx;
    logic             frm_err;
    logic             ovr;

    logic done_rise;
    logic is_last;
    logic fire;

    assign done_rise = arr_done & ~done_q;
    assign is_last   = (idx == LAST_IDX);
    assign fire      = (state == STREAM) & out_ready;

    // Remember the previous done level; reset to 0 so a done already high
    // at reset release is seen as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= arr_done;
        end
    end

    // Frame sequencer: capture on an edge while idle, then walk the index
    // one step per handshake and return to idle after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            frm_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        frm_err <= arr_err;
                        idx     <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        if (is_last) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Snapshot buffer: written only on a capture in idle, so a held frame
    // is never disturbed by later array activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                frame_buf[n] <= '0;
            end
        end else if (state == IDLE && done_rise) begin
            for (int n = 0; n < N; n++) begin
                frame_buf[n] <= arr_out[n*32 +: 32];
            end
        end
    end

    // Sticky overrun: set by an edge while streaming (including the last
    // handshake cycle); the set takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (done_rise && state == STREAM) begin
            ovr <= 1'b1;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end
    end

    // Outputs derive only from registers, never from out_ready. Data fields
    // are forced to zero while idle.
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_dat   = (state == STREAM) ? frame_buf[idx] : 32'h0;
    assign out_idx   = idx;
    assign out_last  = (state == STREAM) & is_last;
    assign out_err   = (state == STREAM) & frm_err;
    assign overrun   = ovr;

endmodule

// File: tb/tb_sys_array_drain.sv
// Self-checking bench for sys_array_drain (M=2, K=2).
module tb_sys_array_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        arr_done;
    logic        arr_err;
    logic [3:0][31:0] arr_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dat;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_err;
    logic        busy;
    logic        overrun;
    logic        clr_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  idx;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0][31:0] w;
        logic             err;
        int               mode;
        logic             exp_err;
    } vec_t;

    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    // stall tracking for the monitor
    logic        s_prev;
    logic [31:0] s_dat;
    logic [1:0]  s_idx;
    logic        s_last;
    logic        s_err;

    always #5 clk = ~clk;

    sys_array_drain #(.M(2), .K(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .arr_done  (arr_done),
        .arr_err   (arr_err),
        .arr_out   (arr_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_dat),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [3:0][31:0] w, input logic err);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.dat  = w[i];
            e.idx  = 2'(i);
            e.last = (i == 3);
            e.err  = err;
            sb.push_back(e);
        end
    endtask

    // Drive ready per mode until the scoreboard empties and the DUT is idle.
    task automatic drain(input int mode);
        int c;
        c = 0;
        while ((sb.size() != 0 || busy) && c < 60) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[c % 7] != 0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            c++;
        end
        check("frame_drained", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        arr_out  = v.w;
        arr_err  = v.err;
        arr_done = 1'b1;
        push_frame(v.w, v.exp_err);
        tick();
        arr_err = ~v.err;
        arr_out = ~v.w;
        drain(v.mode);
        arr_done = 1'b0;
        tick();
    endtask

    // Monitor: compare every handshake with the scoreboard and check that a
    // stalled word holds still.
    always @(negedge clk) begin
        if (rst) begin
            s_prev = 1'b0;
        end else begin
            if (s_prev) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_dat",   out_dat, s_dat);
                check("stall_idx",   {30'd0, out_idx}, {30'd0, s_idx});
                check("stall_last",  {31'd0, out_last}, {31'd0, s_last});
                check("stall_err",   {31'd0, out_err}, {31'd0, s_err});
            end
            if (out_valid) begin
                check("busy_eq_valid", {31'd0, busy}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {30'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_dat",  out_dat, e.dat);
                    check("word_idx",  {30'd0, out_idx}, {30'd0, e.idx});
                    check("word_last", {31'd0, out_last}, {31'd0, e.last});
                    check("word_err",  {31'd0, out_err}, {31'd0, e.err});
                end
            end
            s_prev = out_valid && !out_ready;
            s_dat  = out_dat;
            s_idx  = out_idx;
            s_last = out_last;
            s_err  = out_err;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   {31'd0, out_valid}, 32'd0);
        check({tag, "_dat"},     out_dat, 32'd0);
        check({tag, "_idx"},     {30'd0, out_idx}, 32'd0);
        check({tag, "_last"},    {31'd0, out_last}, 32'd0);
        check({tag, "_err"},     {31'd0, out_err}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [3:0][31:0] fa, fx, fy, fz, fw, r1, r2;

        fa = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        vecs[0] = '{w: fa, err: 1'b1, mode: 1, exp_err: 1'b1};
        vecs[1] = '{w: {32'hC0490FDB, 32'h7F800000, 32'h00000001, 32'hBF800000},
                    err: 1'b0, mode: 1, exp_err: 1'b0};
        vecs[2] = '{w: {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0},
                    err: 1'b0, mode: 2, exp_err: 1'b0};
        vecs[3] = '{w: {32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000},
                    err: 1'b1, mode: 0, exp_err: 1'b1};

        rst       = 1'b1;
        arr_done  = 1'b0;
        arr_err   = 1'b0;
        arr_out   = '0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        tick();
        tick();

        // exact latency and throughput with ready held high
        arr_out   = fa;
        out_ready = 1'b1;
        arr_done  = 1'b1;
        push_frame(fa, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("lat_idx",   {30'd0, out_idx}, k);
            check("lat_last",  {31'd0, out_last}, {31'd0, (k == 3)});
            tick();
        end
        @(negedge clk);
        check("lat_valid_end", {31'd0, out_valid}, 32'd0);
        check("lat_busy_end",  {31'd0, busy}, 32'd0);
        check("lat_sb_empty",  sb.size(), 0);
        tick();
        arr_done  = 1'b0;
        out_ready = 1'b0;
        tick();

        // table-driven frames: data patterns, error capture, ready patterns
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i]);
        end

        // done held high for 20 cycles gives exactly one frame
        arr_out   = fa;
        arr_done  = 1'b1;
        out_ready = 1'b1;
        push_frame(fa, 1'b0);
        repeat (20) tick();
        check("held_sb_empty", sb.size(), 0);
        check("held_overrun",  {31'd0, overrun}, 32'd0);
        check("held_busy",     {31'd0, busy}, 32'd0);
        arr_done  = 1'b0;
        out_ready = 1'b0;
        tick();

        // overrun: new edge while streaming with ready low
        fx = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        fy = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        arr_out  = fx;
        arr_done = 1'b1;
        push_frame(fx, 1'b0);
        tick();
        tick();
        arr_done = 1'b0;
        tick();
        arr_out  = fy;
        arr_done = 1'b1;
        tick();
        @(negedge clk);
        check("ovr_set",      {31'd0, overrun}, 32'd1);
        check("ovr_busy",     {31'd0, busy}, 32'd1);
        check("ovr_hold_dat", out_dat, fx[0]);
        tick();
        drain(0);
        arr_done = 1'b0;
        tick();

        // second overrun edge together with clr_ovr: set wins
        fz = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        arr_out  = fz;
        arr_done = 1'b1;
        push_frame(fz, 1'b0);
        tick();
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        arr_done = 1'b0;
        tick();
        arr_out  = fy;
        arr_done = 1'b1;
        clr_ovr  = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        tick();
        drain(1);
        arr_done = 1'b0;
        tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // edge landing on the last-handshake cycle is an overrun
        fw = {32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D, 32'hFEEDFACE};
        arr_out   = fw;
        arr_done  = 1'b1;
        out_ready = 1'b1;
        push_frame(fw, 1'b0);
        tick();
        tick();
        arr_done = 1'b0;
        tick();
        tick();
        arr_out  = fy;
        arr_done = 1'b1;
        tick();
        check("last_edge_ovr",  {31'd0, overrun}, 32'd1);
        check("last_edge_idle", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("last_edge_no_retrig", {31'd0, busy}, 32'd0);
        check("last_edge_sb_empty",  sb.size(), 0);
        arr_done  = 1'b0;
        out_ready = 1'b0;
        clr_ovr   = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tick();

        // reset after two handshakes, release with done high
        r1 = {32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
        r2 = {32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};
        arr_out   = r1;
        arr_done  = 1'b1;
        out_ready = 1'b1;
        push_frame(r1, 1'b0);
        tick();
        tick();
        tick();
        check("rst_two_popped", sb.size(), 2);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        arr_out = r2;
        tick();
        tick();
        rst = 1'b0;
        push_frame(r2, 1'b0);
        tick();
        @(negedge clk);
        check("rst_restart_valid", {31'd0, out_valid}, 32'd1);
        check("rst_restart_idx",   {30'd0, out_idx}, 32'd0);
        tick();
        drain(0);
        arr_done = 1'b0;
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
